// File: rtl/icb_csr_slave.sv
// icb_csr_slave: terminates one ICB port into a bank of byte-writable control
// registers, answering every command through an in-order response FIFO.
// Optional feature macro: ICB_CSR_STATUS_EN adds the stat_in port and maps
// NUM_STAT read-only status words directly after the control registers.
module icb_csr_slave #(
   parameter int          DATA_W    = 32,
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          RSP_DEPTH = 2,
   parameter int          NUM_STAT  = 4
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         icb_cmd_valid,
   output logic                         icb_cmd_ready,
   input  logic                         icb_cmd_read,
   input  logic [31:0]                  icb_cmd_addr,
   input  logic [DATA_W-1:0]            icb_cmd_wdata,
   input  logic [DATA_W/8-1:0]          icb_cmd_wmask,
   output logic                         icb_rsp_valid,
   input  logic                         icb_rsp_ready,
   output logic [DATA_W-1:0]            icb_rsp_rdata,
   output logic                         icb_rsp_err,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
`ifdef ICB_CSR_STATUS_EN
   input  logic [NUM_STAT*DATA_W-1:0]   stat_in,
`endif
   output logic [NUM_REGS-1:0]          reg_wr_pulse
);

   localparam int BYTES  = DATA_W / 8;
   localparam int SHIFT  = $clog2(BYTES);
`ifdef ICB_CSR_STATUS_EN
   localparam int STAT_ON = 1;
`else
   localparam int STAT_ON = 0;
`endif
   localparam int TOTAL  = NUM_REGS + STAT_ON * NUM_STAT;
   localparam int REG_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

   localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(RSP_DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(RSP_DEPTH);
   localparam logic [31:0]      ALIGN_MASK = 32'(BYTES - 1);
   localparam logic [31:0]      TOTAL_W    = 32'(TOTAL);
   localparam logic [31:0]      NREG_W     = 32'(NUM_REGS);

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [31:0]       offset;
   logic [31:0]       idx;
   logic [REG_IW-1:0] reg_sel;
   logic              aligned;
   logic              legal;
   logic              is_ctrl;
   logic              accept;
   logic              pop;
   logic              push;
   logic              wr_ok;
   logic              rsp_err_in;
   logic [DATA_W-1:0] rd_data;

   assign offset  = icb_cmd_addr - BASE_ADDR;
   assign idx     = offset >> SHIFT;
   assign reg_sel = idx[REG_IW-1:0];
   assign aligned = (offset & ALIGN_MASK) == 32'd0;
   assign legal   = (icb_cmd_addr >= BASE_ADDR) && aligned && (idx < TOTAL_W);
   assign is_ctrl = idx < NREG_W;

   // ---------------------------------------------------------------------
   // Response FIFO state
   // ---------------------------------------------------------------------
   logic [DATA_W:0]    fifo_mem [RSP_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [PTR_W-1:0]   wr_ptr_next;
   logic [PTR_W-1:0]   rd_ptr_next;
   logic [DATA_W:0]    head;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign pop           = icb_rsp_valid && icb_rsp_ready;
   assign icb_cmd_ready = (count_reg < DEPTH_CNT) || pop;
   assign accept        = icb_cmd_valid && icb_cmd_ready;
   assign push          = accept;

   // Writes land only on control registers; status words are read-only.
   assign wr_ok      = accept && !icb_cmd_read && legal && is_ctrl;
   assign rsp_err_in = !legal || (!icb_cmd_read && !is_ctrl);

   assign wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
   assign rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;

   // Read data mux: register or status word as seen at the acceptance edge.
`ifdef ICB_CSR_STATUS_EN
   logic [31:0] stat_sel;
   assign stat_sel = idx - NREG_W;
`endif
   always_comb begin
      rd_data = '0;
      if (icb_cmd_read && legal) begin
         if (is_ctrl) begin
            rd_data = reg_q[reg_sel*DATA_W +: DATA_W];
         end
`ifdef ICB_CSR_STATUS_EN
         else begin
            rd_data = stat_in[stat_sel*DATA_W +: DATA_W];
         end
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Control registers, one slice per register
   // ---------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_W-1:0] word_reg;
         logic              pulse_reg;
         logic              hit;

         assign hit = wr_ok && (reg_sel == REG_IW'(gi));

         // Byte-masked update; unmasked bytes keep their value.
         always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
               word_reg <= '0;
            end else if (hit) begin
               for (int b = 0; b < BYTES; b++) begin
                  if (icb_cmd_wmask[b]) begin
                     word_reg[b*8 +: 8] <= icb_cmd_wdata[b*8 +: 8];
                  end
               end
            end
         end

         // Write strobe fires for any legal write, even with an empty mask.
         always_ff @(posedge clk or negedge rst_) begin
            if (!rst_) begin
               pulse_reg <= 1'b0;
            end else begin
               pulse_reg <= hit;
            end
         end

         assign reg_q[gi*DATA_W +: DATA_W] = word_reg;
         assign reg_wr_pulse[gi]           = pulse_reg;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Response FIFO
   // ---------------------------------------------------------------------
   // Storage array is not reset; the output is gated by valid instead.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {rd_data, rsp_err_in};
      end
   end

   // Pointers wrap at RSP_DEPTH; simultaneous push and pop hold the count.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_next;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_next;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head          = fifo_mem[rd_ptr_reg];
   assign icb_rsp_valid = (count_reg != '0);
   assign icb_rsp_rdata = icb_rsp_valid ? head[DATA_W:1] : '0;
   assign icb_rsp_err   = icb_rsp_valid & head[0];

endmodule

// File: tb/tb_icb_csr_slave.sv
// tb_icb_csr_slave: randomized and directed stimulus for icb_csr_slave with a
// queue-based scoreboard; a monitor pops expected responses on each handshake.
module tb_icb_csr_slave;

   localparam int          DW   = 32;
   localparam int          NR   = 16;
   localparam int          DEP  = 2;
   localparam int          NS   = 4;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic             clk;
   logic             rst_;
   logic             icb_cmd_valid;
   logic             icb_cmd_ready;
   logic             icb_cmd_read;
   logic [31:0]      icb_cmd_addr;
   logic [DW-1:0]    icb_cmd_wdata;
   logic [DW/8-1:0]  icb_cmd_wmask;
   logic             icb_rsp_valid;
   logic             icb_rsp_ready;
   logic [DW-1:0]    icb_rsp_rdata;
   logic             icb_rsp_err;
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;
`ifdef ICB_CSR_STATUS_EN
   logic [NS*DW-1:0] stat_in;
`endif

   icb_csr_slave #(
      .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(BASE), .RSP_DEPTH(DEP), .NUM_STAT(NS)
   ) dut (
      .clk(clk),
      .rst_(rst_),
      .icb_cmd_valid(icb_cmd_valid),
      .icb_cmd_ready(icb_cmd_ready),
      .icb_cmd_read(icb_cmd_read),
      .icb_cmd_addr(icb_cmd_addr),
      .icb_cmd_wdata(icb_cmd_wdata),
      .icb_cmd_wmask(icb_cmd_wmask),
      .icb_rsp_valid(icb_rsp_valid),
      .icb_rsp_ready(icb_rsp_ready),
      .icb_rsp_rdata(icb_rsp_rdata),
      .icb_rsp_err(icb_rsp_err),
      .reg_q(reg_q),
`ifdef ICB_CSR_STATUS_EN
      .stat_in(stat_in),
`endif
      .reg_wr_pulse(reg_wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [31:0]   mdl [NR];
   logic [NR-1:0] exp_pulse;
   logic [32:0]   exp_q [$];
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            mon_en = 0;
   bit            rand_rdy = 0;
   bit            rdy_fixed = 1;
   bit            pend_wr = 0;
   int            pend_idx = 0;
   logic [31:0]   pend_data;
   logic [3:0]    pend_mask;

   function automatic logic [NR*DW-1:0] pack_model();
      logic [NR*DW-1:0] v;
      for (int i = 0; i < NR; i++) v[i*DW +: DW] = mdl[i];
      return v;
   endfunction

   task automatic check(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Decide the response for a command from the address map rules.
   task automatic model_accept(input bit rd, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wm);
      bit          ok;
      logic [31:0] data;
      logic [31:0] off;
      int          idx;
      ok   = 1;
      data = 32'h0;
      if (addr < BASE) begin
         ok = 0;
      end else begin
         off = addr - BASE;
         if (off % 4 != 0 || off / 4 >= 1024) begin
            ok = 0;
         end else begin
            idx = int'(off / 4);
            if (rd) begin
               if (idx < NR) data = mdl[idx];
`ifdef ICB_CSR_STATUS_EN
               else if (idx < NR + NS) data = stat_in[(idx-NR)*DW +: DW];
`endif
               else ok = 0;
            end else if (idx < NR) begin
               pend_wr   = 1;
               pend_idx  = idx;
               pend_data = wdata;
               pend_mask = wm;
            end else begin
               ok = 0;
            end
         end
      end
      exp_q.push_back({ok ? data : 32'h0, !ok});
   endtask

   // Apply the effect of the edge just passed to the model.
   task automatic model_edge();
      exp_pulse = '0;
      if (pend_wr) begin
         for (int b = 0; b < 4; b++)
            if (pend_mask[b]) mdl[pend_idx][b*8 +: 8] = pend_data[b*8 +: 8];
         exp_pulse[pend_idx] = 1'b1;
      end
      pend_wr = 0;
   endtask

   task automatic issue(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wm, output int waits);
      waits = 0;
      @(negedge clk);
      icb_cmd_valid = 1'b1;
      icb_cmd_read  = rd;
      icb_cmd_addr  = addr;
      icb_cmd_wdata = wdata;
      icb_cmd_wmask = wm;
      #1;
      while (!icb_cmd_ready) begin
         if (waits >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_accept_timeout: got ready=0 expected acceptance at addr %h", addr);
            icb_cmd_valid = 1'b0;
            return;
         end
         waits++;
         @(posedge clk);
         model_edge();
         @(negedge clk);
         #1;
      end
      $display("cmd %s addr=%h wdata=%h wmask=%b", rd ? "RD" : "WR", addr, wdata, wm);
      model_accept(rd, addr, wdata, wm);
      @(posedge clk);
      model_edge();
   endtask

   task automatic idle();
      @(negedge clk);
      icb_cmd_valid = 1'b0;
      @(posedge clk);
      model_edge();
   endtask

   task automatic drain();
      int guard;
      rand_rdy  = 0;
      rdy_fixed = 1;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         idle();
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d responses outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Response-ready driver: fixed value or random backpressure.
   initial begin
      icb_rsp_ready = 1'b1;
      forever begin
         @(negedge clk);
         icb_rsp_ready = rand_rdy ? 1'($urandom % 2) : rdy_fixed;
      end
   end

   // Monitor: compares each popped response and the register outputs.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (mon_en) begin
            check("reg_q", reg_q, pack_model());
            check("reg_wr_pulse", {{(NR*DW-NR){1'b0}}, reg_wr_pulse}, {{(NR*DW-NR){1'b0}}, exp_pulse});
            if (icb_rsp_valid && icb_rsp_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL rsp_unexpected: got rdata=%h err=%b expected no response",
                           icb_rsp_rdata, icb_rsp_err);
               end else begin
                  e = exp_q.pop_front();
                  $display("rsp rdata=%h err=%b (exp %h/%b)", icb_rsp_rdata, icb_rsp_err, e[32:1], e[0]);
                  check("rsp", {{(NR*DW-33){1'b0}}, icb_rsp_rdata, icb_rsp_err}, {{(NR*DW-33){1'b0}}, e});
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int w;
      int total_w;
      int r;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;

      rst_          = 1'b0;
      icb_cmd_valid = 1'b0;
      icb_cmd_read  = 1'b0;
      icb_cmd_addr  = '0;
      icb_cmd_wdata = '0;
      icb_cmd_wmask = '0;
      exp_pulse     = '0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
`ifdef ICB_CSR_STATUS_EN
      for (int i = 0; i < NS; i++) stat_in[i*DW +: DW] = $urandom;
      stat_in[1*DW +: DW] = 32'h1234_5678;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_ = 1'b1;
      #1;
      check("reset_ready", {{(NR*DW-1){1'b0}}, icb_cmd_ready}, 1);
      check("reset_rsp_valid", {{(NR*DW-1){1'b0}}, icb_rsp_valid}, 0);
      check("reset_reg_q", reg_q, 0);
      mon_en = 1;

      // Reset read of register 1
      issue(1, BASE + 32'h4, 32'h0, 4'h0, w);
      drain();

      // Byte mask write then read-back
      issue(0, BASE + 32'hC, 32'hAABB_CCDD, 4'b0101, w);
      #1;
      check("bytemask_reg3", {{(NR*DW-32){1'b0}}, reg_q[3*DW +: DW]}, 32'h00BB_00DD);
      check("bytemask_pulse", {{(NR*DW-NR){1'b0}}, reg_wr_pulse}, 16'h0008);
      issue(1, BASE + 32'hC, 32'h0, 4'h0, w);
      drain();

      // Error cases, plus a zero-mask write that still pulses
      issue(1, BASE + 32'h40, 32'h0, 4'h0, w);
      issue(0, BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, w);
      issue(1, BASE - 32'h4, 32'h0, 4'h0, w);
      issue(0, BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, w);
      drain();

      // Backpressure: third command waits for the first pop
      rdy_fixed = 0;
      issue(1, BASE + 32'hC, 32'h0, 4'h0, w);
      issue(1, BASE + 32'h0, 32'h0, 4'h0, w);
      @(negedge clk);
      icb_cmd_valid = 1'b1;
      icb_cmd_read  = 1'b1;
      icb_cmd_addr  = BASE + 32'h8;
      #1;
      check("bp_ready_low", {{(NR*DW-1){1'b0}}, icb_cmd_ready}, 0);
      @(posedge clk);
      model_edge();
      rdy_fixed = 1;
      @(negedge clk);
      #1;
      check("bp_ready_on_pop", {{(NR*DW-1){1'b0}}, icb_cmd_ready}, 1);
      $display("cmd RD addr=%h (accepted with pop)", icb_cmd_addr);
      model_accept(1, icb_cmd_addr, 32'h0, 4'h0);
      @(posedge clk);
      model_edge();
      drain();

      // Streaming: alternating write/read pairs, no stalls allowed
      total_w = 0;
      for (int i = 0; i < 32; i++) begin
         r = $urandom % NR;
         d = $urandom;
         m = 4'($urandom);
         issue(0, BASE + 32'(r * 4), d, m, w);
         total_w += w;
         issue(1, BASE + 32'(r * 4), 32'h0, 4'h0, w);
         total_w += w;
      end
      check("stream_stalls", 512'(total_w), 0);
      drain();

      // Randomized mix under random backpressure
      rand_rdy = 1;
      for (int i = 0; i < 200; i++) begin
         case ($urandom % 8)
            0, 1, 2, 3, 4: a = BASE + 32'(($urandom % NR) * 4);
            5:             a = BASE + 32'(($urandom % NR) * 4 + 1 + $urandom % 3);
            6:             a = BASE + 32'((NR + $urandom % 8) * 4);
            default:       a = BASE - 32'(4 * (1 + $urandom % 4));
         endcase
         issue(1'($urandom % 2), a, $urandom, 4'($urandom), w);
      end
      drain();

`ifdef ICB_CSR_STATUS_EN
      issue(1, BASE + 32'((NR + 1) * 4), 32'h0, 4'h0, w);
      issue(0, BASE + 32'((NR + 1) * 4), 32'h0, 4'hF, w);
      drain();
`endif

      // Reset with two responses pending
      issue(0, BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, w);
      drain();
      rdy_fixed = 0;
      issue(1, BASE + 32'h14, 32'h0, 4'h0, w);
      issue(1, BASE + 32'h0, 32'h0, 4'h0, w);
      idle();
      @(negedge clk);
      #3;
      mon_en = 0;
      rst_   = 1'b0;
      #1;
      check("midrst_rsp_valid", {{(NR*DW-1){1'b0}}, icb_rsp_valid}, 0);
      check("midrst_rsp_err", {{(NR*DW-1){1'b0}}, icb_rsp_err}, 0);
      check("midrst_rsp_rdata", {{(NR*DW-DW){1'b0}}, icb_rsp_rdata}, 0);
      check("midrst_ready", {{(NR*DW-1){1'b0}}, icb_cmd_ready}, 1);
      check("midrst_reg_q", reg_q, 0);
      check("midrst_pulse", {{(NR*DW-NR){1'b0}}, reg_wr_pulse}, 0);
      exp_q.delete();
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      pend_wr   = 0;
      exp_pulse = '0;
      rdy_fixed = 1;
      @(negedge clk);
      rst_ = 1'b1;
      @(posedge clk);
      mon_en = 1;
      issue(1, BASE + 32'h14, 32'h0, 4'h0, w);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
